// File: rtl/instr_fetch_stage.sv
// IF stage of the 16-bit MIPS pipeline: owns the PC and feeds IF/ID.
// Handles stall, redirect+flush, and a HALT word that freezes fetch.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   stall            hold PC and IF/ID this cycle
//   redirect         taken branch/jump; loads redirect_pc and flushes
//   redirect_pc      target byte address (bit 0 forced to 0)
//   imem_addr        byte address to async-read memory (= pc)
//   imem_instr       word returned for imem_addr in the same cycle
//   if_id_instr      registered instruction to decode
//   if_id_pc_next    registered pc+2 of that instruction
//   if_id_valid      IF/ID holds a real instruction
//   halted           fetch frozen by a HALT word
//   fetch_count      saturating count of valid IF/ID loads
module instr_fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_next,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  if_id_t      if_id_q;
  if_id_t      if_id_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  logic [15:0] pc_inc;
  logic [15:0] cnt_inc;
  logic        run_go;
  logic        take_redir;
  logic        take_hold;
  logic        take_bub;
  logic        take_halt;
  logic        take_adv;

  assign pc_inc  = pc_q + 16'd2;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q
                                       : cnt_q + 16'd1;

  // One-hot action select, priority folded in here
  // so the decoder below is truly exclusive.
  assign take_redir = redirect;
  assign take_hold  = !redirect && stall;
  assign take_bub   = !redirect && !stall
                   && (state_q == HALT);
  assign run_go     = !redirect && !stall
                   && (state_q == RUN);
  assign take_halt  = run_go
                   && (imem_instr == HALT_INSTR);
  assign take_adv   = run_go
                   && (imem_instr != HALT_INSTR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      take_redir: begin
        pc_d          = redirect_pc & 16'hFFFE;
        if_id_d.instr = 16'h0000;
        if_id_d.valid = 1'b0;
        state_d       = RUN;
      end
      take_hold: begin
        state_d = state_q;
      end
      take_bub: begin
        if_id_d.instr = 16'h0000;
        if_id_d.valid = 1'b0;
      end
      take_halt: begin
        // HALT word is issued; pc parks on it
        if_id_d.instr   = imem_instr;
        if_id_d.pc_next = pc_inc;
        if_id_d.valid   = 1'b1;
        cnt_d           = cnt_inc;
        state_d         = HALT;
      end
      take_adv: begin
        if_id_d.instr   = imem_instr;
        if_id_d.pc_next = pc_inc;
        if_id_d.valid   = 1'b1;
        cnt_d           = cnt_inc;
        pc_d            = pc_inc;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC & 16'hFFFE;
      if_id_q <= '0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_id_instr   = if_id_q.instr;
  assign if_id_pc_next = if_id_q.pc_next;
  assign if_id_valid   = if_id_q.valid;
  assign halted        = (state_q == HALT);
  assign fetch_count   = cnt_q;

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage of the 16-bit MIPS pipeline: owns the program counter, drives the byte address into the asynchronous-read instruction memory, and captures the returned 16-bit instruction into the IF/ID pipeline register. It handles pipeline stalls, branch/jump redirects with flush, and a halt instruction that freezes fetch. It also keeps a saturating count of issued instructions for debug.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)
- HALT_INSTR, 16'hFFFF, instruction encoding that stops fetch
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, synchronous, active-low
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- redirect  input  1  branch/jump resolved taken this cycle
- redirect_pc  input  16  target byte address; bit 0 ignored (forced 0)
- imem_addr  output  16  byte address to instruction memory (= pc, combinational)
- imem_instr  input  16  instruction from memory, valid in the same cycle as imem_addr
- if_id_instr  output  16  registered instruction to decode
- if_id_pc_next  output  16  registered pc+2 of that instruction
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- halted  output  1  high while in HALT state
- fetch_count  output  16  number of valid instructions latched into IF/ID, saturating

## Operation
- State machine: RUN, HALT. Reset enters RUN.
- Per-cycle priority (highest first): reset, redirect, stall, halt detection, normal advance.
- Reset (rst_n=0 at edge): pc=RESET_PC, if_id_instr=16'h0000, if_id_pc_next=16'h0000, if_id_valid=0, fetch_count=0, state=RUN, halted=0.
- Redirect (any state, regardless of stall): pc={redirect_pc[15:1],1'b0}; IF/ID loads bubble (instr=0, valid=0, pc_next unchanged); state=RUN; count unchanged.
- Stall without redirect: pc, IF/ID, count and state hold; in HALT, stall changes nothing.
- RUN, normal: IF/ID loads {imem_instr, pc+2, valid=1}; pc=pc+2; count+1 unless it is 16'hFFFF.
- RUN, imem_instr==HALT_INSTR, no stall or redirect: the halt instruction is latched as valid (count+1); pc holds at the halt address; state=HALT.
- HALT: pc holds; IF/ID loads a bubble each non-stalled cycle; only redirect or reset leaves HALT.
- Arithmetic: pc+2 is modulo 2^16 (16'hFFFE -> 16'h0000); no overflow flag. Memory aliasing above its depth is the memory's concern; fetch drives all 16 bits.
- halted = (state==HALT), registered.

## Timing
- Zero-cycle memory path: imem_addr equals the current pc combinationally; imem_instr is sampled at the same edge that advances pc.
- Fetch-to-decode latency: 1 cycle (instruction at pc appears on if_id_instr after the next edge).
- Redirect penalty: 1 bubble; the target instruction is valid in IF/ID 2 edges after the redirect edge.
- Stall asserted for N cycles holds IF/ID contents for exactly N cycles; no instruction is lost or duplicated.
- Reset mid-stream or mid-HALT takes effect at the next edge, overriding stall and redirect.
- Redirect and HALT_INSTR in the same cycle: redirect wins, the halt instruction is discarded, and state=RUN.

## Test plan
- Reset/sequential: memory returns {8'h00, addr[8:1]}; release rst_n -> imem_addr 0,2,4,...; if_id_instr 0000,0001,0002 with pc_next 2,4,6; valid rises 1 cycle after reset release; fetch_count increments by 1 per cycle.
- Stall: stall high for 3 cycles at pc=6 -> imem_addr stays 6 and IF/ID holds instr 0002 for 3 cycles; then 0003 is issued with no gap or duplicate.
- Redirect with odd target: redirect_pc=16'h0041 while stall=1 -> next pc=0x0040, one bubble (valid=0), then instr 0020 valid; count skips the bubble.
- Halt: memory returns 16'hFFFF at 0x000A -> FFFF latched valid; halted=1 next edge; pc stuck at 0x000A; bubbles follow; redirect_pc=0 -> halted=0 and fetch restarts at 0.
- Wrap and saturation: redirect to 0xFFFE -> next pc 0x0000 and if_id_pc_next=0x0000; preload the count near 16'hFFFF by running 65535 fetches -> it holds at FFFF.
- Reset mid-HALT and mid-stall: rst_n=0 -> all outputs return to reset values after one edge, state=RUN.
